// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory initiator and its helpers.
package dmem_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int REG_W   = 3;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_REQ,
    DM_BUSY,
    DM_RESP
  } dm_state_t;

endpackage

// File: rtl/dmem_timer.sv
// Saturating cycle counter shared by the REQ and BUSY watchdogs.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  // Expired in the cycle whose closing edge brings the count up to the limit.
  assign expired = ({1'b0, count} + 9'd1) >= {1'b0, limit};

endmodule

// File: rtl/dmem_initiator.sv
// CPU-side initiator for the 8-bit busy_wait data memory: issues one load or
// store per CU request, stalls the core while busy, returns load write-back.
module dmem_initiator
  import dmem_pkg::*;
#(
  parameter int START_TIMEOUT = 16,
  parameter int DONE_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_W-1:0]  req_rd,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              busy_wait,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [TIMER_W-1:0] START_LIMIT = TIMER_W'(START_TIMEOUT);
  localparam logic [TIMER_W-1:0] DONE_LIMIT  = TIMER_W'(DONE_TIMEOUT);

  dm_state_t          state, state_next;
  logic               op_write;
  logic               accept, drop_strobes, capture, timeout;
  logic [TIMER_W-1:0] timer_limit;
  logic               timer_clear, timer_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    timer_limit  = START_LIMIT;
    accept       = 1'b0;
    drop_strobes = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state)
      DM_IDLE: begin
        // A high busy_wait here is a leftover access from before reset.
        if (req_valid && !busy_wait) begin
          accept     = 1'b1;
          state_next = DM_REQ;
        end
      end
      DM_REQ: begin
        if (busy_wait) begin
          drop_strobes = 1'b1;
          state_next   = DM_BUSY;
        end else if (timer_expired) begin
          drop_strobes = 1'b1;
          timeout      = 1'b1;
          state_next   = DM_IDLE;
        end
      end
      DM_BUSY: begin
        timer_limit = DONE_LIMIT;
        if (!busy_wait) begin
          capture    = !op_write;
          state_next = DM_RESP;
        end else if (timer_expired) begin
          timeout    = 1'b1;
          state_next = DM_IDLE;
        end
      end
      DM_RESP: state_next = DM_IDLE;
      default: state_next = DM_IDLE;
    endcase
  end

  // Restart the watchdog on every state entry and keep it parked while idle.
  assign timer_clear = (state == DM_IDLE) || (state_next != state);

  dmem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
      op_write  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= timeout;
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        wb_addr   <= req_rd;
        op_write  <= req_write;
        mem_read  <= !req_write;
        mem_write <= req_write;
      end else if (drop_strobes) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (capture) begin
        wb_data <= mem_rdata;
      end
    end
  end

  assign wb_valid = (state == DM_RESP) && !op_write;
  assign stall    = (state != DM_IDLE) || req_valid;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator with a behavioural busy_wait memory model.
module tb_dmem_initiator;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [7:0]  req_addr, req_wdata;
  logic [2:0]  req_rd;
  logic        stall, wb_valid, err, mem_read, mem_write;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data, mem_addr, mem_wdata;
  logic        busy_wait = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;

  always #5 clk = ~clk;

  dmem_initiator #(.START_TIMEOUT(16), .DONE_TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .err       (err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy_wait (busy_wait),
    .mem_rdata (mem_rdata)
  );

  // Memory model. mode 0: busy for mem_lat cycles; 1: ignores strobes; 2: busy forever.
  logic [7:0] mem_array [256];
  logic       mem_ready = 1'b0;
  int         mem_mode = 0;
  int         mem_lat = 1;
  int         access_count = 0;
  int         m_cnt = 0;
  logic [7:0] m_addr = 8'd0, m_wdata = 8'd0;
  logic       m_write = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++)
        mem_array[i] <= (i == 0) ? 8'd9 : (i == 1) ? 8'd3 : (8'(i) ^ 8'h5A);
      mem_ready <= 1'b1;
    end else if (busy_wait) begin
      if (mem_mode != 2) begin
        if (m_cnt == 0) begin
          busy_wait <= 1'b0;
          if (m_write) mem_array[m_addr] <= m_wdata;
          else         mem_rdata <= mem_array[m_addr];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if ((mem_read || mem_write) && mem_mode != 1) begin
      busy_wait    <= 1'b1;
      m_cnt        <= mem_lat - 1;
      m_addr       <= mem_addr;
      m_wdata      <= mem_wdata;
      m_write      <= mem_write;
      access_count <= access_count + 1;
    end
  end

  int both_strobes = 0;
  always @(negedge clk) if (mem_read && mem_write) both_strobes <= both_strobes + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  int wait_c, gap_c, stall_c, strobe_c, wb_c, wb_d, wb_a, err_c;

  // Issue one request, wait for it to be taken, then measure the transaction.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [2:0] rd);
    int guard;
    wait_c = 0; gap_c = 0; stall_c = 0; strobe_c = 0;
    wb_c = 0; wb_d = -1; wb_a = -1; err_c = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_rd = rd;
    do begin
      @(negedge clk);
      if (!(mem_read || mem_write)) begin
        wait_c++;
        if (!stall) gap_c++;
      end
    end while (!(mem_read || mem_write) && wait_c < 400);
    req_valid = 1'b0;
    guard = 0;
    while (stall && guard < 1000) begin
      stall_c++;
      if (mem_read || mem_write) strobe_c++;
      if (wb_valid) begin
        wb_c++;
        wb_d = int'(wb_data);
        wb_a = int'(wb_addr);
      end
      if (err) err_c++;
      @(negedge clk);
      guard++;
    end
    repeat (2) begin
      if (err) err_c++;
      if (wb_valid) wb_c++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] rd;
    int         lat;
    int         exp_wb;
    int         exp_data;
  } vec_t;

  vec_t vecs[5];
  int   acc0;
  int   wb_t[2], wb_dv[2], wb_av[2];
  int   wb_seen, cyc, guard;
  logic first_seen;

  initial begin
    vecs[0] = '{1'b1, 8'd4,   8'd17,  3'd0, 10, 0, 0};
    vecs[1] = '{1'b0, 8'd4,   8'd0,   3'd5, 3,  1, 17};
    vecs[2] = '{1'b0, 8'hFF,  8'd0,   3'd7, 1,  1, 8'hA5};
    vecs[3] = '{1'b1, 8'h80,  8'hC3,  3'd0, 2,  0, 0};
    vecs[4] = '{1'b0, 8'h80,  8'd0,   3'd0, 5,  1, 8'hC3};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'd0; req_wdata = 8'd0; req_rd = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_stall",     int'(stall), 0);
    check("reset_mem_read",  int'(mem_read), 0);
    check("reset_mem_write", int'(mem_write), 0);
    check("reset_wb_valid",  int'(wb_valid), 0);
    check("reset_err",       int'(err), 0);
    check("reset_mem_addr",  int'(mem_addr), 0);
    check("reset_mem_wdata", int'(mem_wdata), 0);
    check("reset_wb_addr",   int'(wb_addr), 0);
    check("reset_wb_data",   int'(wb_data), 0);
    req_valid = 1'b1;
    #1 check("reset_stall_follows_req", int'(stall), 1);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Table: store 17 to 4 then load it into r5, plus other address/latency mixes.
    for (int i = 0; i < 5; i++) begin
      mem_mode = 0;
      mem_lat  = vecs[i].lat;
      acc0     = access_count;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      check($sformatf("v%0d_accept_wait", i), wait_c, 0);
      check($sformatf("v%0d_stall_cycles", i), stall_c, vecs[i].lat + 3);
      check($sformatf("v%0d_strobe_cycles", i), strobe_c, 2);
      check($sformatf("v%0d_wb_pulses", i), wb_c, vecs[i].exp_wb);
      check($sformatf("v%0d_err", i), err_c, 0);
      check($sformatf("v%0d_accesses", i), access_count - acc0, 1);
      if (vecs[i].exp_wb != 0) begin
        check($sformatf("v%0d_wb_data", i), wb_d, vecs[i].exp_data);
        check($sformatf("v%0d_wb_addr", i), wb_a, int'(vecs[i].rd));
      end
    end

    // Start timeout: memory never raises busy_wait.
    mem_mode = 1;
    acc0 = access_count;
    run_txn(1'b0, 8'd7, 8'd0, 3'd1);
    check("start_to_stall_cycles",  stall_c, 16);
    check("start_to_strobe_cycles", strobe_c, 16);
    check("start_to_err_pulses",    err_c, 1);
    check("start_to_wb_pulses",     wb_c, 0);
    check("start_to_accesses",      access_count - acc0, 0);

    // Done timeout: memory holds busy_wait high forever.
    mem_mode = 2;
    mem_lat  = 1;
    run_txn(1'b0, 8'd8, 8'd0, 3'd1);
    check("done_to_stall_cycles", stall_c, 257);
    check("done_to_err_pulses",   err_c, 1);
    check("done_to_wb_pulses",    wb_c, 0);
    check("done_to_idle_strobes", int'(mem_read || mem_write), 0);
    mem_mode = 0;
    guard = 0;
    while (busy_wait && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("done_to_mem_release", int'(busy_wait), 0);

    // Reset while BUSY, then a request while the old access is still running.
    mem_lat = 20;
    acc0 = access_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd1; req_rd = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy_mem_read", int'(mem_read), 0);
    check("rst_busy_mem_addr", int'(mem_addr), 0);
    check("rst_busy_wb_addr",  int'(wb_addr), 0);
    check("rst_busy_stall",    int'(stall), 0);
    mem_lat = 2;
    run_txn(1'b0, 8'd0, 8'd0, 3'd3);
    check("rst_busy_accept_wait", wait_c, 15);
    check("rst_busy_stall_gaps",  gap_c, 0);
    check("rst_busy_stall_cycles", stall_c, 5);
    check("rst_busy_wb_data",     wb_d, 9);
    check("rst_busy_wb_addr",     wb_a, 3);
    check("rst_busy_accesses",    access_count - acc0, 2);

    // Back-to-back loads with req_valid held high.
    mem_lat = 1;
    wb_seen = 0; cyc = 0; first_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd0; req_rd = 3'd1;
    while (wb_seen < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!first_seen && mem_read) begin
        first_seen = 1'b1;
        req_addr = 8'd1;
        req_rd   = 3'd2;
      end
      if (wb_valid) begin
        wb_t[wb_seen]  = cyc;
        wb_dv[wb_seen] = int'(wb_data);
        wb_av[wb_seen] = int'(wb_addr);
        wb_seen++;
      end
    end
    req_valid = 1'b0;
    check("b2b_pulses", wb_seen, 2);
    if (wb_seen == 2) begin
      check("b2b_first_data",  wb_dv[0], 9);
      check("b2b_first_addr",  wb_av[0], 1);
      check("b2b_second_data", wb_dv[1], 3);
      check("b2b_second_addr", wb_av[1], 2);
      check("b2b_spacing_ge4", int'(wb_t[1] - wb_t[0] >= 4), 1);
    end
    repeat (6) @(negedge clk);
    check("never_both_strobes", both_strobes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_initiator.md
# dmem_initiator

CPU-side initiator for the 8-bit data-memory busy_wait protocol. It accepts one load or store per request from the control unit and drives `read`/`write`/`address`/`write_data` to the data memory. It holds the PC and register file stalled while the memory is busy, then returns load data as a one-cycle register write-back strobe. It sits between the CU/regfile and the data memory, replacing direct CU-to-memory wiring.

## Interface
Parameters:
- `START_TIMEOUT`, 16: cycles allowed in REQ for memory to raise `busy_wait`.
- `DONE_TIMEOUT`, 255: cycles allowed in BUSY for memory to drop `busy_wait`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: CU requests a memory op this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 8: memory address.
- `req_wdata` input 8: store data.
- `req_rd` input 3: load destination register.
- `stall` output 1: hold PC/regfile; combinational.
- `wb_valid` output 1: load data valid, one-cycle pulse.
- `wb_addr` output 3: destination register for `wb_data`.
- `wb_data` output 8: loaded byte.
- `err` output 1: one-cycle pulse on timeout.
- `mem_read` output 1: to memory `read`.
- `mem_write` output 1: to memory `write`.
- `mem_addr` output 8: to memory `address`.
- `mem_wdata` output 8: to memory `write_data`.
- `busy_wait` input 1: from memory.
- `mem_rdata` input 8: from memory `read_data`.

## Operation
- States: IDLE, REQ, BUSY, RESP.
- IDLE: if `req_valid && !busy_wait` → latch `req_*` into `mem_addr`, `mem_wdata`, `wb_addr`, and op. Set `mem_read = !req_write` or `mem_write = req_write`; go to REQ. If `busy_wait` is high (stale transaction after reset), do not accept.
- REQ: `busy_wait` sampled 1 → clear `mem_read`/`mem_write` (prevents memory retrigger) and go to BUSY. Timer reaching `START_TIMEOUT` → clear strobes, pulse `err`, go to IDLE.
- BUSY: `mem_addr`/`mem_wdata` held stable. `busy_wait` sampled 0 → for a load, capture `mem_rdata` into `wb_data`; go to RESP. Timer reaching `DONE_TIMEOUT` → pulse `err`, go to IDLE, no write-back.
- RESP: `wb_valid = 1` for a load only (0 for a store); go to IDLE.
- `stall = (state != IDLE) || (req_valid && state == IDLE)`. The accepting edge therefore never advances the PC.
- `mem_read` and `mem_write` are never both 1.
- The timer resets on every state entry and saturates.
- Widths: the timer is 8 bits, so `DONE_TIMEOUT` must be ≤ 255. No arithmetic on data.

## Timing
- Reset values: state IDLE; `mem_read`, `mem_write`, `wb_valid`, `err` = 0; `mem_addr`, `mem_wdata`, `wb_addr`, `wb_data` = 0; timer 0. `stall` follows `req_valid`.
- Reset mid-transaction: the next edge forces IDLE with strobes low. Any in-flight memory op completes unobserved. A new request waits until `busy_wait` = 0.
- Load latency: accept edge E0 → REQ. Memory busy for N edges. Capture at the first edge with `busy_wait` = 0 → RESP. `wb_valid` is high for exactly one cycle, and `stall` drops in that same RESP cycle's following IDLE.
- Minimum spacing between accepts is 4 cycles, assuming zero memory delay.
- `err` and `wb_valid` are never high in the same cycle.

## Structure
- Package `dmem_pkg`: state enum (`DM_IDLE`, `DM_REQ`, `DM_BUSY`, `DM_RESP`), `ADDR_W` = 8, `DATA_W` = 8, `REG_W` = 3.
- Sub-module `dmem_timer`: 8-bit saturating counter with `clear` and `expired` (compare against a limit input), shared by REQ and BUSY.

## Test plan
- Store then load: store 17 to address 4 with memory busy for 10 clk cycles. Expected: `mem_write` high until `busy_wait` rises; `stall` high throughout; no `wb_valid`. Then load address 4 into r5. Expected: `wb_valid` for one cycle with `wb_addr` = 5 and `wb_data` = 17.
- Retrigger guard: memory responds busy for 3 cycles. Expected: `mem_read` is 0 from the edge after `busy_wait` rises, and memory performs exactly one access.
- Start timeout: `busy_wait` held 0 after a load request. Expected: `err` pulses at 16 cycles, strobes drop, `stall` releases, no `wb_valid`.
- Done timeout: `busy_wait` stuck at 1. Expected: `err` at 255 cycles in BUSY, return to IDLE.
- Reset in BUSY, then a request while `busy_wait` is still 1. Expected: outputs at reset values; the request is not accepted (`stall` = 1) until `busy_wait` falls, then it proceeds normally.
- Back-to-back: `req_valid` held high for two loads (addresses 0 and 1, holding 9 and 3). Expected: two separate `wb_valid` pulses carrying 9 then 3, at least 4 cycles apart.
